// File: rtl/rs_simple.sv
`default_nettype none
// ============================================================================
//  Module   : rs_simple
//  Purpose  : Two-entry reservation station for the simple integer unit.
//             Holds dispatched instructions until both source operands are
//             valid and captures operand values from two result broadcast
//             buses while waiting. Both entries are always presented to the
//             execute stage, which reports back which entry it issued.
//  Ports    : clk, rst (sync, active-high), flush (sync clear)
//             dispatch_valid / dispatch_inst / dispatch_rob_num -> dispatch_ready
//             cdb0_* / cdb1_*          result broadcasts (valid, rob tag, data)
//             rs_simple_0/1            entry contents (zero when empty)
//             rs_simple_0/1_entry_num  ROB number of each entry (zero when empty)
//             selector                 index of the newer occupied entry
//             simple_0/1_issue         execute stage consumed entry 0 / 1
//  Revision : 1.0 - initial release
// ============================================================================
module rs_simple #(
   parameter int ENTRIES = 2,
   parameter int W       = 114
) (
   input  logic         clk,
   input  logic         rst,
   input  logic         flush,
   input  logic         dispatch_valid,
   input  logic [W-1:0] dispatch_inst,
   input  logic [3:0]   dispatch_rob_num,
   output logic         dispatch_ready,
   input  logic         cdb0_valid,
   input  logic [3:0]   cdb0_rob_num,
   input  logic [31:0]  cdb0_data,
   input  logic         cdb1_valid,
   input  logic [3:0]   cdb1_rob_num,
   input  logic [31:0]  cdb1_data,
   output logic [W-1:0] rs_simple_0,
   output logic [W-1:0] rs_simple_1,
   output logic [3:0]   rs_simple_0_entry_num,
   output logic [3:0]   rs_simple_1_entry_num,
   output logic         selector,
   input  logic         simple_0_issue,
   input  logic         simple_1_issue
);

   // Operand field positions inside an entry
   localparam int S1_V  = 5;
   localparam int S1_LO = 6;
   localparam int S2_V  = 38;
   localparam int S2_LO = 39;

   logic [ENTRIES-1:0]        busy_q,  busy_d;
   logic [ENTRIES-1:0][W-1:0] entry_q, entry_d;
   logic [ENTRIES-1:0][3:0]   rob_q,   rob_d;
   logic                      selector_q, selector_d;

   logic [ENTRIES-1:0]        issue;
   logic [ENTRIES-1:0]        free;
   logic                      alloc;
   logic                      slot;
   logic [W-1:0]              dispatch_woken;

   // Wake one operand: cdb0 is tested last so it overrides cdb1 on a double hit.
   function automatic logic [32:0] wake_op(
      input logic [31:0] val,
      input logic        vld,
      input logic        c0_v,
      input logic [3:0]  c0_tag,
      input logic [31:0] c0_d,
      input logic        c1_v,
      input logic [3:0]  c1_tag,
      input logic [31:0] c1_d
   );
      logic [32:0] res;
      res = {vld, val};
      if (!vld) begin
         if (c1_v && (c1_tag == val[3:0])) res = {1'b1, c1_d};
         if (c0_v && (c0_tag == val[3:0])) res = {1'b1, c0_d};
      end
      return res;
   endfunction

   // Apply wakeup to both operands of an entry image.
   function automatic logic [W-1:0] wake_entry(
      input logic [W-1:0] e,
      input logic         c0_v,
      input logic [3:0]   c0_tag,
      input logic [31:0]  c0_d,
      input logic         c1_v,
      input logic [3:0]   c1_tag,
      input logic [31:0]  c1_d
   );
      logic [W-1:0] r;
      logic [32:0]  o1;
      logic [32:0]  o2;
      r  = e;
      o1 = wake_op(e[S1_LO +: 32], e[S1_V], c0_v, c0_tag, c0_d, c1_v, c1_tag, c1_d);
      o2 = wake_op(e[S2_LO +: 32], e[S2_V], c0_v, c0_tag, c0_d, c1_v, c1_tag, c1_d);
      r[S1_LO +: 32] = o1[31:0];
      r[S1_V]        = o1[32];
      r[S2_LO +: 32] = o2[31:0];
      r[S2_V]        = o2[32];
      return r;
   endfunction

   // A slot is reusable in the same cycle it is issued from.
   assign issue          = {simple_1_issue, simple_0_issue};
   assign free           = ~busy_q | issue;
   assign dispatch_ready = |free;
   assign alloc          = dispatch_valid & dispatch_ready;
   assign slot           = ~free[0];

   assign dispatch_woken = wake_entry(dispatch_inst,
                                      cdb0_valid, cdb0_rob_num, cdb0_data,
                                      cdb1_valid, cdb1_rob_num, cdb1_data);

   always_comb begin
      busy_d     = '0;
      entry_d    = '0;
      rob_d      = '0;
      selector_d = selector_q;
      for (int k = 0; k < ENTRIES; k++) begin
         if (alloc && (int'(slot) == k)) begin
            busy_d[k]  = 1'b1;
            entry_d[k] = dispatch_woken;
            rob_d[k]   = dispatch_rob_num;
         end else if (busy_q[k] && !issue[k]) begin
            busy_d[k]  = 1'b1;
            entry_d[k] = wake_entry(entry_q[k],
                                    cdb0_valid, cdb0_rob_num, cdb0_data,
                                    cdb1_valid, cdb1_rob_num, cdb1_data);
            rob_d[k]   = rob_q[k];
         end
         // Empty slots are held at zero so the outputs read zero directly.
      end
      if (alloc) begin
         selector_d = slot;
      end else if (busy_d == '0) begin
         selector_d = 1'b0;
      end
   end

   always_ff @(posedge clk) begin
      if (rst || flush) begin
         busy_q     <= '0;
         entry_q    <= '0;
         rob_q      <= '0;
         selector_q <= 1'b0;
      end else begin
         busy_q     <= busy_d;
         entry_q    <= entry_d;
         rob_q      <= rob_d;
         selector_q <= selector_d;
      end
   end

   assign rs_simple_0           = entry_q[0];
   assign rs_simple_1           = entry_q[1];
   assign rs_simple_0_entry_num = rob_q[0];
   assign rs_simple_1_entry_num = rob_q[1];
   assign selector              = selector_q;

endmodule
`default_nettype wire

// File: tb/tb_rs_simple.sv
`default_nettype none
// ============================================================================
//  Module   : tb_rs_simple
//  Purpose  : Directed self-checking bench for rs_simple.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_rs_simple;

   localparam int W = 114;

   logic         clk = 1'b0;
   logic         rst;
   logic         flush;
   logic         dispatch_valid;
   logic [W-1:0] dispatch_inst;
   logic [3:0]   dispatch_rob_num;
   logic         dispatch_ready;
   logic         cdb0_valid;
   logic [3:0]   cdb0_rob_num;
   logic [31:0]  cdb0_data;
   logic         cdb1_valid;
   logic [3:0]   cdb1_rob_num;
   logic [31:0]  cdb1_data;
   logic [W-1:0] rs_simple_0;
   logic [W-1:0] rs_simple_1;
   logic [3:0]   rs_simple_0_entry_num;
   logic [3:0]   rs_simple_1_entry_num;
   logic         selector;
   logic         simple_0_issue;
   logic         simple_1_issue;

   int checks = 0;
   int errors = 0;

   rs_simple #(.ENTRIES(2), .W(W)) dut (
      .clk                   (clk),
      .rst                   (rst),
      .flush                 (flush),
      .dispatch_valid        (dispatch_valid),
      .dispatch_inst         (dispatch_inst),
      .dispatch_rob_num      (dispatch_rob_num),
      .dispatch_ready        (dispatch_ready),
      .cdb0_valid            (cdb0_valid),
      .cdb0_rob_num          (cdb0_rob_num),
      .cdb0_data             (cdb0_data),
      .cdb1_valid            (cdb1_valid),
      .cdb1_rob_num          (cdb1_rob_num),
      .cdb1_data             (cdb1_data),
      .rs_simple_0           (rs_simple_0),
      .rs_simple_1           (rs_simple_1),
      .rs_simple_0_entry_num (rs_simple_0_entry_num),
      .rs_simple_1_entry_num (rs_simple_1_entry_num),
      .selector              (selector),
      .simple_0_issue        (simple_0_issue),
      .simple_1_issue        (simple_1_issue)
   );

   always #5 clk = ~clk;

   // Issue must only target an occupied entry with both operands valid.
   always @(posedge clk) begin
      if (!rst && !flush) begin
         if (simple_0_issue) assert (rs_simple_0[5] && rs_simple_0[38]);
         if (simple_1_issue) assert (rs_simple_1[5] && rs_simple_1[38]);
      end
   end

   task automatic check(input string tag, input logic [W-1:0] obs, input logic [W-1:0] exp);
      checks++;
      if (obs !== exp) begin
         errors++;
         $display("FAIL %s: got %h expected %h", tag, obs, exp);
      end
   endtask

   function automatic logic [W-1:0] mk(input logic [4:0] rd,
                                       input logic [31:0] s1, input logic s1v,
                                       input logic [31:0] s2, input logic s2v);
      return {32'hC0DE_0000, 6'h15, 4'h2, 1'b1, s2, s2v, s1, s1v, rd};
   endfunction

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic idle();
      rst = 0; flush = 0;
      dispatch_valid = 0; dispatch_inst = '0; dispatch_rob_num = '0;
      cdb0_valid = 0; cdb0_rob_num = '0; cdb0_data = '0;
      cdb1_valid = 0; cdb1_rob_num = '0; cdb1_data = '0;
      simple_0_issue = 0; simple_1_issue = 0;
   endtask

   task automatic dispatch(input logic [W-1:0] inst, input logic [3:0] rob);
      dispatch_valid = 1; dispatch_inst = inst; dispatch_rob_num = rob;
   endtask

   task automatic check_empty(input string tag);
      check({tag, "_rs0"},  rs_simple_0, '0);
      check({tag, "_rs1"},  rs_simple_1, '0);
      check({tag, "_en0"},  W'(rs_simple_0_entry_num), '0);
      check({tag, "_en1"},  W'(rs_simple_1_entry_num), '0);
      check({tag, "_sel"},  W'(selector), '0);
      check({tag, "_rdy"},  W'(dispatch_ready), W'(1));
   endtask

   logic [W-1:0] a, b, c, d, e, p, q;

   initial begin
      idle();
      rst = 1;
      tick(); tick();
      rst = 0;
      #1;
      check_empty("reset");

      // Fully-ready dispatch, then issue.
      a = mk(5'd3, 32'd5, 1'b1, 32'd7, 1'b1);
      dispatch(a, 4'd2);
      tick(); idle(); #1;
      check("t1_rs0", rs_simple_0, a);
      check("t1_s1v", W'(rs_simple_0[5]), W'(1));
      check("t1_s2v", W'(rs_simple_0[38]), W'(1));
      check("t1_en0", W'(rs_simple_0_entry_num), W'(2));
      check("t1_sel", W'(selector), '0);
      check("t1_rs1", rs_simple_1, '0);
      simple_0_issue = 1;
      tick(); idle(); #1;
      check("t1_iss_rs0", rs_simple_0, '0);
      check("t1_iss_en0", W'(rs_simple_0_entry_num), '0);

      // Wakeup from cdb1; a non-matching tag has no effect.
      b = mk(5'd1, 32'd9, 1'b0, 32'd7, 1'b1);
      dispatch(b, 4'd3);
      tick(); idle();
      cdb1_valid = 1; cdb1_rob_num = 4'd8; cdb1_data = 32'h1111_1111;
      tick(); idle(); #1;
      check("t2_nomatch", rs_simple_0, b);
      cdb1_valid = 1; cdb1_rob_num = 4'd9; cdb1_data = 32'hDEAD_BEEF;
      tick(); idle(); #1;
      check("t2_s1", W'(rs_simple_0[37:6]), W'(32'hDEAD_BEEF));
      check("t2_s1v", W'(rs_simple_0[5]), W'(1));
      check("t2_rs0", rs_simple_0, mk(5'd1, 32'hDEAD_BEEF, 1'b1, 32'd7, 1'b1));
      simple_0_issue = 1;
      tick(); idle();

      // Dispatch-cycle wakeup; both CDBs hit, cdb0 wins.
      c = mk(5'd4, 32'd5, 1'b1, 32'd4, 1'b0);
      dispatch(c, 4'd7);
      cdb0_valid = 1; cdb0_rob_num = 4'd4; cdb0_data = 32'h0000_1234;
      cdb1_valid = 1; cdb1_rob_num = 4'd4; cdb1_data = 32'h0000_5555;
      tick(); idle(); #1;
      check("t3_rs0", rs_simple_0, mk(5'd4, 32'd5, 1'b1, 32'h1234, 1'b1));
      check("t3_en0", W'(rs_simple_0_entry_num), W'(7));
      simple_0_issue = 1;
      tick(); idle();

      // Fill both entries; a further dispatch is dropped.
      a = mk(5'd10, 32'd1, 1'b1, 32'd2, 1'b1);
      b = mk(5'd11, 32'd3, 1'b1, 32'd4, 1'b1);
      dispatch(a, 4'd1);
      tick(); idle();
      dispatch(b, 4'd5);
      tick(); idle(); #1;
      check("t4_rs0", rs_simple_0, a);
      check("t4_rs1", rs_simple_1, b);
      check("t4_en1", W'(rs_simple_1_entry_num), W'(5));
      check("t4_sel", W'(selector), W'(1));
      check("t4_rdy", W'(dispatch_ready), '0);
      d = mk(5'd12, 32'd6, 1'b1, 32'd6, 1'b1);
      dispatch(d, 4'd11);
      tick(); idle(); #1;
      check("t4_drop_rs0", rs_simple_0, a);
      check("t4_drop_rs1", rs_simple_1, b);
      check("t4_drop_en1", W'(rs_simple_1_entry_num), W'(5));

      // Issue entry 0 and dispatch C into the freed slot in the same cycle.
      c = mk(5'd13, 32'd8, 1'b1, 32'd9, 1'b1);
      simple_0_issue = 1;
      dispatch(c, 4'd6);
      #1;
      check("t5_rdy", W'(dispatch_ready), W'(1));
      tick(); idle(); #1;
      check("t5_rs0", rs_simple_0, c);
      check("t5_en0", W'(rs_simple_0_entry_num), W'(6));
      check("t5_sel", W'(selector), '0);
      check("t5_rs1", rs_simple_1, b);

      // Selector only moves on allocation, and drops to 0 when empty.
      simple_1_issue = 1;
      tick(); idle(); #1;
      check("sel_rs1_empty", rs_simple_1, '0);
      e = mk(5'd14, 32'd1, 1'b1, 32'd1, 1'b1);
      dispatch(e, 4'd12);
      tick(); idle(); #1;
      check("sel_e_rs1", rs_simple_1, e);
      check("sel_after_alloc1", W'(selector), W'(1));
      simple_0_issue = 1;
      tick(); idle(); #1;
      check("sel_hold", W'(selector), W'(1));
      simple_1_issue = 1;
      tick(); idle(); #1;
      check("sel_empty", W'(selector), '0);
      check("sel_empty_rdy", W'(dispatch_ready), W'(1));

      // Reset and flush override dispatch and wakeup with pending tags.
      p = mk(5'd2, 32'd3, 1'b0, 32'd1, 1'b1);
      q = mk(5'd6, 32'd1, 1'b1, 32'd3, 1'b0);
      for (int pass = 0; pass < 2; pass++) begin
         dispatch(p, 4'd2);
         tick(); idle();
         dispatch(q, 4'd4);
         tick(); idle(); #1;
         check("clr_full_rdy", W'(dispatch_ready), '0);
         if (pass == 0) rst = 1; else flush = 1;
         dispatch(a, 4'd9);
         cdb0_valid = 1; cdb0_rob_num = 4'd3; cdb0_data = 32'hABCD_0000;
         tick(); idle(); #1;
         check_empty(pass == 0 ? "rst" : "flush");
      end

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
`default_nettype wire

// File: doc/rs_simple.md
# rs_simple

Two-entry reservation station feeding the simple integer functional unit. It accepts dispatched instructions and holds them until both source operands are ready. While waiting, it captures operand values from two result broadcast buses. It presents both entries to the simple execute stage and frees whichever entry that stage reports as issued.

## Interface
- `ENTRIES`, 2, fixed entry count; not to be changed.
- `W`, 114, entry width. Fields: `[113:82]` reserved (stored and passed through), `[81:76]` aluop, `[75:72]` memwrite/memread/memtoreg/branch, `[71]` regwrite, `[70:39]` s2, `[38]` s2_valid, `[37:6]` s1, `[5]` s1_valid, `[4:0]` rd.
- `clk  in  1`  clock; all state updates on rising edge.
- `rst  in  1`  synchronous, active-high reset.
- `flush  in  1`  synchronous clear of all entries; has the same effect as reset.
- `dispatch_valid  in  1`  dispatch request.
- `dispatch_inst  in  114`  instruction in entry format.
- `dispatch_rob_num  in  4`  ROB entry number of the dispatched instruction.
- `dispatch_ready  out  1`  the RS accepts a dispatch this cycle.
- `cdb0_valid, cdb1_valid  in  1`  result broadcast valid.
- `cdb0_rob_num, cdb1_rob_num  in  4`  tag of the broadcast result.
- `cdb0_data, cdb1_data  in  32`  broadcast value.
- `rs_simple_0, rs_simple_1  out  114`  entry contents; all zero when the entry is empty.
- `rs_simple_0_entry_num, rs_simple_1_entry_num  out  4`  ROB number of each entry; 0 when the entry is empty.
- `selector  out  1`  index of the newer occupied entry.
- `simple_0_issue, simple_1_issue  in  1`  the execute stage consumed entry 0 / entry 1 this cycle.

## Operation
- State per entry: busy bit, a 114-bit register and a 4-bit ROB number. A global `selector` register is also kept.
- Operand encoding: when `sN_valid` = 0, `sN[3:0]` holds the producer ROB tag and `sN[31:4]` is don't-care.
- Wakeup applies to each busy entry and to each operand with valid = 0:
  - If `cdbK_valid` and `cdbK_rob_num == sN[3:0]`, write `sN <= cdbK_data` and `sN_valid <= 1`.
  - If both CDBs match, cdb0 wins.
- Dispatch-cycle wakeup: the incoming instruction's operands are matched against the same-cycle CDBs before they are stored. No broadcast may be missed.
- `dispatch_ready = !(busy0 & busy1) | simple_0_issue | simple_1_issue`. A slot freed by an issue in the same cycle is reusable in that cycle.
- Allocation:
  - When `dispatch_valid & dispatch_ready`, write the lowest-indexed slot that is free after this cycle's issues are applied.
  - Set `busy <= 1` and `selector <=` that slot's index.
- Issue: `simple_k_issue` clears `busy_k` at the edge. An issue asserted on an empty entry, or on an entry whose operands are not both valid, is a protocol violation and is ignored (bench assertion).
- Both issue signals in one cycle clear both entries; the execute stage never does this, but the RS must tolerate it.
- Selector:
  - It changes only on allocation.
  - When one entry remains after an issue, the selector is left as is; the execute stage ignores it with a single valid entry.
  - When both entries become empty, `selector <= 0`.
- `dispatch_valid` while `!dispatch_ready`: the request is dropped, state is unchanged, and the dispatcher must hold the request.
- Reset or flush sets all busy bits, entry registers, ROB numbers and `selector` to 0. It has priority over dispatch, issue and wakeup in the same cycle.

## Timing
- Reset values: every output is 0, except `dispatch_ready`, which is 1 (derived combinationally from the cleared state).
- Dispatch at edge T: the entry is visible on `rs_simple_k` from T+1.
- An operand already ready at dispatch, or woken up in the dispatch cycle, can issue in cycle T+1.
- Wakeup broadcast in cycle T: `sN_valid` is 1 on the outputs from T+1. There is no combinational CDB-to-output bypass.
- Issue in cycle T: the entry reads all zero from T+1.
- Minimum occupancy is 1 cycle; back-to-back issue from the same slot is possible every cycle with dispatch in the same cycle.
- `dispatch_ready` is combinational from busy bits and issue inputs only. There is no path from `dispatch_valid` to `dispatch_ready`.

## Test plan
- Reset then dispatch `rd=3`, `s1=5`/valid, `s2=7`/valid, rob 2 → next cycle `rs_simple_0[5]=1`, `rs_simple_0[38]=1`, `entry_num_0=2`, `selector=0`. Issue 0 → entry 0 reads 0 the following cycle.
- Dispatch into entry 0 with `s1` tag 9, not valid. `cdb1_valid`, rob 9, data `0xDEADBEEF` two cycles later → `s1=0xDEADBEEF` and `s1_valid=1` one cycle after the broadcast; a broadcast with rob 8 has no effect.
- Dispatch with `s2` tag 4 in the same cycle as `cdb0` rob 4, data `0x1234` → the stored entry shows `s2=0x1234` and `s2_valid=1`.
- Dispatch A (rob 1), then B (rob 5) → entry 0 = A, entry 1 = B, `selector=1`, `dispatch_ready=0`. A further dispatch with no issue is dropped.
- Full RS, `simple_0_issue=1` with dispatch C (rob 6) in the same cycle → `dispatch_ready=1`, C lands in entry 0, `selector=0`, and entry 1 still holds B.
- Full RS with pending operand tags, then `rst=1` (also repeat with `flush=1`) alongside a dispatch and a CDB hit → next cycle all outputs are 0 and `dispatch_ready=1`.
